// File: rtl/instr_pkg.sv
// Shared types and instruction-field positions for the instruction control unit.
// Opcode, ALU and write-select encodings match the instruction set and datapath muxes.
package instr_pkg;

   localparam int OP_HI   = 11;
   localparam int OP_LO   = 9;
   localparam int RD_HI   = 8;
   localparam int RD_LO   = 6;
   localparam int RA_HI   = 5;
   localparam int RA_LO   = 3;
   localparam int RB_HI   = 2;
   localparam int RB_LO   = 0;
   localparam int ADDR_HI = 3;
   localparam int ADDR_LO = 0;
   localparam int IMM_HI  = 5;
   localparam int IMM_LO  = 0;

   typedef enum logic [2:0] {
      OP_LOAD  = 3'b000,
      OP_STORE = 3'b001,
      OP_ADD   = 3'b010,
      OP_SUB   = 3'b011,
      OP_LOADI = 3'b100,
      OP_AND   = 3'b101,
      OP_OR    = 3'b110,
      OP_HALT  = 3'b111
   } opcode_t;

   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_AND = 2'd2,
      ALU_OR  = 2'd3
   } alu_op_t;

   typedef enum logic [1:0] {
      WSEL_ALU = 2'd0,
      WSEL_DM  = 2'd1,
      WSEL_IMM = 2'd2
   } wsel_t;

   typedef enum logic [2:0] {
      CLS_ALU,
      CLS_LOAD,
      CLS_STORE,
      CLS_LOADI,
      CLS_HALT
   } instr_class_t;

   typedef enum logic [2:0] {
      IDLE,
      DECODE,
      EXEC,
      MEM,
      WB,
      HALT
   } state_t;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational opcode decoder: instruction class, ALU operation and RF write-data select.
module instr_field_decode
   import instr_pkg::*;
(
   input  opcode_t      op,
   output instr_class_t cls,
   output alu_op_t      alu_op,
   output wsel_t        wsel
);

   // NOTE: every output gets a default before the case so no path can infer a latch.
   always_comb begin
      cls    = CLS_HALT;
      alu_op = ALU_ADD;
      wsel   = WSEL_ALU;
      case (op)
         OP_LOAD:  begin cls = CLS_LOAD;  wsel = WSEL_DM;  end
         OP_STORE: cls = CLS_STORE;
         OP_ADD:   begin cls = CLS_ALU;   alu_op = ALU_ADD; end
         OP_SUB:   begin cls = CLS_ALU;   alu_op = ALU_SUB; end
         OP_LOADI: begin cls = CLS_LOADI; wsel = WSEL_IMM; end
         OP_AND:   begin cls = CLS_ALU;   alu_op = ALU_AND; end
         OP_OR:    begin cls = CLS_ALU;   alu_op = ALU_OR;  end
         OP_HALT:  cls = CLS_HALT;
         default:  cls = CLS_HALT;
      endcase
   end

endmodule

// File: rtl/instr_ctrl_fsm.sv
// Multi-cycle control unit: latches one instruction per strobe and sequences RF/ALU/DM control.
// All control outputs are registered from the next state so they line up with the state they belong to.
module instr_ctrl_fsm
   import instr_pkg::*;
#(
   parameter int IW    = 12,
   parameter int RF_AW = 3,
   parameter int DM_AW = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             instr_valid,
   input  logic [IW-1:0]    instr,
   output logic             busy,
   output logic             done,
   output logic             halted,
   output logic             overrun,
   output logic [RF_AW-1:0] rf_raddr_a,
   output logic [RF_AW-1:0] rf_raddr_b,
   output logic             rf_we,
   output logic [RF_AW-1:0] rf_waddr,
   output logic [1:0]       rf_wsel,
   output logic [5:0]       imm,
   output logic [1:0]       alu_op,
   output logic [DM_AW-1:0] dm_addr,
   output logic             dm_re,
   output logic             dm_we,
   output logic [CNT_W-1:0] retired
);

   state_t             state_q, state_d;
   logic [IW-1:0]      instr_q, instr_d;
   logic               accept;

   logic               busy_q, busy_d, done_q, done_d;
   logic               halted_q, halted_d, overrun_q, overrun_d;
   logic [RF_AW-1:0]   raddr_a_q, raddr_a_d, raddr_b_q, raddr_b_d;
   logic               rf_we_q, rf_we_d;
   logic [RF_AW-1:0]   waddr_q, waddr_d;
   logic [1:0]         wsel_q, wsel_d;
   logic [5:0]         imm_q, imm_d;
   logic [1:0]         alu_op_q, alu_op_d;
   logic [DM_AW-1:0]   dm_addr_q, dm_addr_d;
   logic               dm_re_q, dm_re_d, dm_we_q, dm_we_d;
   logic [CNT_W-1:0]   retired_q, retired_d;

   opcode_t            f_op;
   logic [RF_AW-1:0]   f_rd, f_ra, f_rb;
   logic [DM_AW-1:0]   f_addr;
   logic [5:0]         f_imm;
   instr_class_t       cls;
   alu_op_t            dec_alu_op;
   wsel_t              dec_wsel;

   // Only IDLE accepts a new instruction; the latch is frozen for the rest of the sequence.
   assign accept  = (state_q == IDLE) && instr_valid;
   assign instr_d = accept ? instr : instr_q;

   assign f_op   = opcode_t'(instr_d[OP_HI:OP_LO]);
   assign f_rd   = instr_d[RD_HI:RD_LO];
   assign f_ra   = instr_d[RA_HI:RA_LO];
   assign f_rb   = instr_d[RB_HI:RB_LO];
   assign f_addr = instr_d[ADDR_HI:ADDR_LO];
   assign f_imm  = instr_d[IMM_HI:IMM_LO];

   instr_field_decode u_decode (
      .op     (f_op),
      .cls    (cls),
      .alu_op (dec_alu_op),
      .wsel   (dec_wsel)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:   if (accept) state_d = DECODE;
         DECODE: begin
            case (cls)
               CLS_ALU:             state_d = EXEC;
               CLS_LOAD, CLS_STORE: state_d = MEM;
               CLS_LOADI:           state_d = WB;
               default:             state_d = HALT;
            endcase
         end
         EXEC:   state_d = WB;
         MEM:    state_d = (cls == CLS_STORE) ? IDLE : WB;
         WB:     state_d = IDLE;
         HALT:   state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_d    = (state_d != IDLE);
      halted_d  = (state_d == HALT);
      done_d    = 1'b0;
      overrun_d = overrun_q | (instr_valid && (state_q != IDLE));
      raddr_a_d = '0;
      raddr_b_d = '0;
      rf_we_d   = 1'b0;
      waddr_d   = '0;
      wsel_d    = '0;
      imm_d     = '0;
      alu_op_d  = '0;
      dm_addr_d = '0;
      dm_re_d   = 1'b0;
      dm_we_d   = 1'b0;
      retired_d = retired_q + CNT_W'(done_q);
      case (state_d)
         DECODE: begin
            // STORE data comes out of port A, so port A carries rs rather than ra.
            raddr_a_d = (cls == CLS_STORE) ? f_rd : f_ra;
            raddr_b_d = f_rb;
         end
         EXEC: begin
            raddr_a_d = f_ra;
            raddr_b_d = f_rb;
            alu_op_d  = dec_alu_op;
         end
         MEM: begin
            dm_addr_d = f_addr;
            if (cls == CLS_STORE) begin
               dm_we_d   = 1'b1;
               raddr_a_d = f_rd;
               done_d    = 1'b1;
            end else begin
               dm_re_d   = 1'b1;
            end
         end
         WB: begin
            rf_we_d = 1'b1;
            waddr_d = f_rd;
            wsel_d  = dec_wsel;
            done_d  = 1'b1;
            if (cls == CLS_LOADI) imm_d = f_imm;
         end
         HALT:    done_d = (state_q != HALT);
         default: ;
      endcase
   end

   // NOTE: reset clears every flop, including the instruction latch, so an abort never leaves a write enable behind.
   // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         instr_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         halted_q  <= 1'b0;
         overrun_q <= 1'b0;
         raddr_a_q <= '0;
         raddr_b_q <= '0;
         rf_we_q   <= 1'b0;
         waddr_q   <= '0;
         wsel_q    <= '0;
         imm_q     <= '0;
         alu_op_q  <= '0;
         dm_addr_q <= '0;
         dm_re_q   <= 1'b0;
         dm_we_q   <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         halted_q  <= halted_d;
         overrun_q <= overrun_d;
         raddr_a_q <= raddr_a_d;
         raddr_b_q <= raddr_b_d;
         rf_we_q   <= rf_we_d;
         waddr_q   <= waddr_d;
         wsel_q    <= wsel_d;
         imm_q     <= imm_d;
         alu_op_q  <= alu_op_d;
         dm_addr_q <= dm_addr_d;
         dm_re_q   <= dm_re_d;
         dm_we_q   <= dm_we_d;
         retired_q <= retired_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign halted     = halted_q;
   assign overrun    = overrun_q;
   assign rf_raddr_a = raddr_a_q;
   assign rf_raddr_b = raddr_b_q;
   assign rf_we      = rf_we_q;
   assign rf_waddr   = waddr_q;
   assign rf_wsel    = wsel_q;
   assign imm        = imm_q;
   assign alu_op     = alu_op_q;
   assign dm_addr    = dm_addr_q;
   assign dm_re      = dm_re_q;
   assign dm_we      = dm_we_q;
   assign retired    = retired_q;

endmodule

// File: tb/tb_instr_ctrl_fsm.sv
// Bench for instr_ctrl_fsm: per-instruction cycle-table model compared every cycle, plus directed literal checks.
module tb_instr_ctrl_fsm;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       halted;
      logic       overrun;
      logic [2:0] ra;
      logic [2:0] rb;
      logic       rf_we;
      logic [2:0] waddr;
      logic [1:0] wsel;
      logic [5:0] imm;
      logic [1:0] alu_op;
      logic [3:0] dm_addr;
      logic       dm_re;
      logic       dm_we;
      logic [7:0] retired;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic [11:0] instr = '0;
   logic        busy, done, halted, overrun, rf_we, dm_re, dm_we;
   logic [2:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
   logic [1:0]  rf_wsel, alu_op;
   logic [5:0]  imm;
   logic [3:0]  dm_addr;
   logic [7:0]  retired;

   int checks = 0;
   int errors = 0;

   obs_t dut_vec;
   obs_t cur = '0;
   obs_t plan_q[$];
   logic m_halted = 1'b0;
   logic m_overrun = 1'b0;
   logic [7:0] m_retired = '0;
   int m_total = 0;

   instr_ctrl_fsm dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
      .busy(busy), .done(done), .halted(halted), .overrun(overrun),
      .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_we(rf_we),
      .rf_waddr(rf_waddr), .rf_wsel(rf_wsel), .imm(imm), .alu_op(alu_op),
      .dm_addr(dm_addr), .dm_re(dm_re), .dm_we(dm_we), .retired(retired)
   );

   always #5 clk = ~clk;

   assign dut_vec = {busy, done, halted, overrun, rf_raddr_a, rf_raddr_b, rf_we,
                     rf_waddr, rf_wsel, imm, alu_op, dm_addr, dm_re, dm_we, retired};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Cycle-by-cycle plan of an accepted instruction, starting with the cycle after the strobe edge.
   task automatic push_plan(input logic [11:0] v);
      logic [2:0] op, rd, ra, rb;
      obs_t base, r;
      op = v[11:9]; rd = v[8:6]; ra = v[5:3]; rb = v[2:0];
      base = '0;
      base.busy = 1'b1;
      r = base; r.ra = (op == 3'b001) ? rd : ra; r.rb = rb;
      plan_q.push_back(r);
      case (op)
         3'b000: begin
            r = base; r.dm_addr = v[3:0]; r.dm_re = 1'b1; plan_q.push_back(r);
            r = base; r.rf_we = 1'b1; r.waddr = rd; r.wsel = 2'd1; r.done = 1'b1; plan_q.push_back(r);
         end
         3'b001: begin
            r = base; r.dm_addr = v[3:0]; r.dm_we = 1'b1; r.ra = rd; r.done = 1'b1; plan_q.push_back(r);
         end
         3'b100: begin
            r = base; r.rf_we = 1'b1; r.waddr = rd; r.wsel = 2'd2; r.imm = v[5:0]; r.done = 1'b1;
            plan_q.push_back(r);
         end
         3'b111: begin
            r = base; r.halted = 1'b1; r.done = 1'b1; plan_q.push_back(r);
            m_halted = 1'b1;
         end
         default: begin
            r = base; r.ra = ra; r.rb = rb;
            r.alu_op = (op == 3'b010) ? 2'd0 : (op == 3'b011) ? 2'd1 : (op == 3'b101) ? 2'd2 : 2'd3;
            plan_q.push_back(r);
            r = base; r.rf_we = 1'b1; r.waddr = rd; r.wsel = 2'd0; r.done = 1'b1; plan_q.push_back(r);
         end
      endcase
   endtask

   // Reference model: advances on each clock edge, resets immediately on rst_n.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            plan_q.delete();
            cur = '0;
            m_halted = 1'b0;
            m_overrun = 1'b0;
            m_retired = '0;
         end else begin
            obs_t nxt;
            if (cur.done) begin
               m_retired++;
               m_total++;
            end
            if (instr_valid) begin
               if (!cur.busy) push_plan(instr);
               else m_overrun = 1'b1;
            end
            if (plan_q.size() > 0) nxt = plan_q.pop_front();
            else begin
               nxt = '0;
               nxt.busy = m_halted;
               nxt.halted = m_halted;
            end
            nxt.overrun = m_overrun;
            nxt.retired = m_retired;
            cur = nxt;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         check("cycle", 64'(dut_vec), 64'(cur));
      end
   end

   task automatic strobe(input logic [11:0] v);
      @(negedge clk);
      instr_valid = 1'b1;
      instr = v;
      @(negedge clk);
      instr_valid = 1'b0;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [11:0] v;
      int iter;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_all_zero", 64'(dut_vec), 64'(0));
      end

      // ADD R3,R1,R2
      strobe(12'h4CA);
      check("add_c1_ra", 64'(rf_raddr_a), 64'(1));
      check("add_c1_rb", 64'(rf_raddr_b), 64'(2));
      wait_cyc(1);
      check("add_c2_aluop", 64'(alu_op), 64'(0));
      check("add_c2_ra", 64'(rf_raddr_a), 64'(1));
      wait_cyc(1);
      check("add_c3_we", 64'(rf_we), 64'(1));
      check("add_c3_waddr", 64'(rf_waddr), 64'(3));
      check("add_c3_wsel", 64'(rf_wsel), 64'(0));
      check("add_c3_done", 64'(done), 64'(1));

      // LOAD R5,[0xA]
      strobe(12'h14A);
      wait_cyc(1);
      check("load_c2_re", 64'(dm_re), 64'(1));
      check("load_c2_addr", 64'(dm_addr), 64'(4'hA));
      wait_cyc(1);
      check("load_c3_we", 64'(rf_we), 64'(1));
      check("load_c3_waddr", 64'(rf_waddr), 64'(5));
      check("load_c3_wsel", 64'(rf_wsel), 64'(1));
      check("retired_after_add", 64'(retired), 64'(1));

      // STORE R2,[3]
      strobe(12'h283);
      check("store_c1_rfwe", 64'(rf_we), 64'(0));
      wait_cyc(1);
      check("store_c2_we", 64'(dm_we), 64'(1));
      check("store_c2_addr", 64'(dm_addr), 64'(3));
      check("store_c2_ra", 64'(rf_raddr_a), 64'(2));
      check("store_c2_done", 64'(done), 64'(1));
      check("store_c2_rfwe", 64'(rf_we), 64'(0));

      // LOADI R7,0x2A
      strobe(12'h9EA);
      wait_cyc(1);
      check("loadi_c2_we", 64'(rf_we), 64'(1));
      check("loadi_c2_waddr", 64'(rf_waddr), 64'(7));
      check("loadi_c2_imm", 64'(imm), 64'(6'h2A));
      check("loadi_c2_wsel", 64'(rf_wsel), 64'(2));

      // Strobe during ADD: dropped, overrun set, ADD unaffected
      strobe(12'h4CA);
      instr_valid = 1'b1;
      instr = 12'h14A;
      @(negedge clk);
      instr_valid = 1'b0;
      check("ovr_set", 64'(overrun), 64'(1));
      check("ovr_c2_aluop", 64'(alu_op), 64'(0));
      wait_cyc(1);
      check("ovr_c3_waddr", 64'(rf_waddr), 64'(3));
      check("ovr_c3_wsel", 64'(rf_wsel), 64'(0));
      wait_cyc(1);
      check("ovr_dropped_idle", 64'(busy), 64'(0));
      check("ovr_no_dmre", 64'(dm_re), 64'(0));

      // Reset pulse during EXEC
      strobe(12'h4CA);
      wait_cyc(1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_rfwe", 64'(rf_we), 64'(0));
      wait_cyc(1);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_cyc(1);
         check("abort_no_rfwe", 64'(rf_we), 64'(0));
      end

      // 256 completions wrap the retired counter
      do_reset();
      for (int i = 0; i < 256; i++) begin
         strobe(12'h800 | 12'(i & 63));
         wait_cyc(1);
         if (i == 255) check("retired_before_wrap", 64'(retired), 64'(255));
      end
      wait_cyc(1);
      check("retired_wrap", 64'(retired), 64'(0));

      // Randomised traffic, with occasional strobes while busy
      do_reset();
      iter = 0;
      while (m_total < 300 && iter < 2000) begin
         v = 12'($urandom);
         if (v[11:9] == 3'b111) v[11:9] = 3'($urandom_range(0, 6));
         strobe(v);
         wait_cyc($urandom_range(0, 5));
         iter++;
      end
      check("random_progress", 64'(m_total >= 300), 64'(1));

      // HALT and strobes after it
      do_reset();
      strobe(12'hE00);
      check("halt_c1_halted", 64'(halted), 64'(0));
      wait_cyc(1);
      check("halt_c2_halted", 64'(halted), 64'(1));
      check("halt_c2_done", 64'(done), 64'(1));
      wait_cyc(1);
      check("halt_c3_done", 64'(done), 64'(0));
      check("halt_c3_retired", 64'(retired), 64'(1));
      strobe(12'h4CA);
      check("halt_ovr", 64'(overrun), 64'(1));
      check("halt_busy", 64'(busy), 64'(1));
      wait_cyc(4);
      check("halt_sticky", 64'(halted), 64'(1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
